// File: rtl/cordic_seq.sv
`default_nettype none
// ============================================================================
// Module      : cordic_seq
// Description : Steps a 16-iteration CORDIC rotator through one operation per
//               request and hands the final sin/cos back over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle_in,
    output logic             in_ready,
    input  logic             abort,
    input  logic [WIDTH-1:0] cordic_sin,
    input  logic [WIDTH-1:0] cordic_cos,
    output logic [WIDTH-1:0] cordic_endangle,
    output logic [AW-1:0]    cordic_addr,
    output logic             cordic_load,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sin_out,
    output logic [WIDTH-1:0] cos_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(ITERS - 1);
    localparam logic [AW-1:0] C_ADDR_ONE  = AW'(1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] endangle_q, endangle_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic             load_q,     load_d;
    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] sin_q,      sin_d;
    logic [WIDTH-1:0] cos_q,      cos_d;

    always_comb begin
        state_d    = state_q;
        endangle_d = endangle_q;
        addr_d     = addr_q;
        load_d     = 1'b0;
        valid_d    = valid_q;
        sin_d      = sin_q;
        cos_d      = cos_q;

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) begin
                    endangle_d = angle_in;
                    load_d     = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = C_ADDR_ONE;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else if (addr_q == C_LAST_ADDR) begin
                    state_d = S_WAIT;
                end else begin
                    addr_d = addr_q + C_ADDR_ONE;
                end
            end
            S_WAIT: begin
                // Abort takes priority over the capture on this edge.
                if (abort) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    sin_d   = cordic_sin;
                    cos_d   = cordic_cos;
                    valid_d = 1'b1;
                    addr_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                addr_d  = '0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            endangle_q <= '0;
            addr_q     <= '0;
            load_q     <= 1'b0;
            valid_q    <= 1'b0;
            sin_q      <= '0;
            cos_q      <= '0;
        end else begin
            state_q    <= state_d;
            endangle_q <= endangle_d;
            addr_q     <= addr_d;
            load_q     <= load_d;
            valid_q    <= valid_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign busy            = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_WAIT);
    assign cordic_endangle = endangle_q;
    assign cordic_addr     = addr_q;
    assign cordic_load     = load_q;
    assign out_valid       = valid_q;
    assign sin_out         = sin_q;
    assign cos_out         = cos_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_seq
// Description : Directed self-checking bench for cordic_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] angle_in;
    logic        in_ready;
    logic        abort;
    logic [15:0] cordic_sin;
    logic [15:0] cordic_cos;
    logic [15:0] cordic_endangle;
    logic [3:0]  cordic_addr;
    logic        cordic_load;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sin_out;
    logic [15:0] cos_out;

    int checks   = 0;
    int failures = 0;

    cordic_seq #(.WIDTH(16), .ITERS(16), .AW(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .angle_in        (angle_in),
        .in_ready        (in_ready),
        .abort           (abort),
        .cordic_sin      (cordic_sin),
        .cordic_cos      (cordic_cos),
        .cordic_endangle (cordic_endangle),
        .cordic_addr     (cordic_addr),
        .cordic_load     (cordic_load),
        .busy            (busy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sin_out         (sin_out),
        .cos_out         (cos_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; angle_in = '0; abort = 1'b0;
        cordic_sin = 16'h1234; cordic_cos = 16'h4321; out_ready = 1'b0;
        #2;
        checks++;
        if (cordic_endangle !== 16'h0 || cordic_addr !== 4'h0 || cordic_load !== 1'b0 ||
            busy !== 1'b0 || out_valid !== 1'b0 || sin_out !== 16'h0 || cos_out !== 16'h0 ||
            in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_por: endangle=%h addr=%h load=%b busy=%b valid=%b sin=%h cos=%h in_ready=%b, required all 0 and in_ready=1",
                cordic_endangle, cordic_addr, cordic_load, busy, out_valid, sin_out, cos_out, in_ready); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL reset_release: in_ready=%b busy=%b valid=%b, required 1/0/0", in_ready, busy, out_valid); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_addr;
        start = 1'b1; angle_in = 16'h2500;
        tick();
        start = 1'b0; angle_in = 16'h0;
        checks++;
        if (cordic_endangle !== 16'h2500 || cordic_load !== 1'b1 || cordic_addr !== 4'h0 ||
            busy !== 1'b1 || in_ready !== 1'b0)
            begin failures++; $display("FAIL basic_load: endangle=%h load=%b addr=%h busy=%b in_ready=%b, required 2500/1/0/1/0",
                cordic_endangle, cordic_load, cordic_addr, busy, in_ready); end
        cordic_sin = 16'h1101; cordic_cos = 16'h2201;
        for (int k = 2; k <= 17; k++) begin
            tick();
            exp_addr = (k <= 16) ? 4'(k - 1) : 4'hF;
            checks++;
            if (cordic_addr !== exp_addr || cordic_load !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1)
                begin failures++; $display("FAIL basic_iter cycle %0d: addr=%h load=%b valid=%b busy=%b, required addr=%h load=0 valid=0 busy=1",
                    k, cordic_addr, cordic_load, out_valid, busy, exp_addr); end
            cordic_sin = 16'h1100 + 16'(k);
            cordic_cos = 16'h2200 + 16'(k);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || sin_out !== 16'h1111 || cos_out !== 16'h2211 || busy !== 1'b0)
            begin failures++; $display("FAIL basic_result: valid=%b sin=%h cos=%h busy=%b, required 1/1111/2211/0",
                out_valid, sin_out, cos_out, busy); end
    endtask

    // Result held under backpressure; abort and start in DONE must be ignored.
    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cordic_sin = 16'hDEAD ^ 16'(k);
            cordic_cos = 16'hBEEF ^ 16'(k);
            abort    = (k == 1);
            start    = (k == 2);
            angle_in = 16'h4000;
            tick();
            checks++;
            if (out_valid !== 1'b1 || sin_out !== 16'h1111 || cos_out !== 16'h2211 || in_ready !== 1'b0)
                begin failures++; $display("FAIL hold cycle %0d: valid=%b sin=%h cos=%h in_ready=%b, required 1/1111/2211/0",
                    k, out_valid, sin_out, cos_out, in_ready); end
        end
        abort = 1'b0; start = 1'b0; angle_in = 16'h0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || cordic_endangle !== 16'h2500)
            begin failures++; $display("FAIL handoff: valid=%b in_ready=%b busy=%b endangle=%h, required 0/1/0/2500",
                out_valid, in_ready, busy, cordic_endangle); end
    endtask

    task automatic test_abort();
        int bad;
        start = 1'b1; angle_in = 16'h3000;
        tick();
        start = 1'b0;
        repeat (7) tick();
        checks++;
        if (cordic_addr !== 4'h7)
            begin failures++; $display("FAIL abort_pre: addr=%h, required 7", cordic_addr); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (cordic_addr !== 4'h0 || cordic_load !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL abort_idle: addr=%h load=%b busy=%b in_ready=%b valid=%b, required 0/0/0/1/0",
                cordic_addr, cordic_load, busy, in_ready, out_valid); end
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0)
            begin failures++; $display("FAIL abort_quiet: %0d cycles with valid or busy set, required 0", bad); end
    endtask

    task automatic test_abort_wait();
        start = 1'b1; angle_in = 16'h0777;
        cordic_sin = 16'hBEEF; cordic_cos = 16'hCAFE;
        tick();
        start = 1'b0;
        repeat (16) tick();
        checks++;
        if (cordic_addr !== 4'hF || busy !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL abort_wait_pre: addr=%h busy=%b valid=%b, required f/1/0", cordic_addr, busy, out_valid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sin_out !== 16'h1111 || cos_out !== 16'h2211 || cordic_addr !== 4'h0)
            begin failures++; $display("FAIL abort_wait: valid=%b in_ready=%b sin=%h cos=%h addr=%h, required 0/1/1111/2211/0",
                out_valid, in_ready, sin_out, cos_out, cordic_addr); end
    endtask

    task automatic test_reset_mid_op();
        int n;
        start = 1'b1; angle_in = 16'h2500;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++;
        if (cordic_addr !== 4'h9)
            begin failures++; $display("FAIL reset_mid_pre: addr=%h, required 9", cordic_addr); end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (cordic_endangle !== 16'h0 || cordic_addr !== 4'h0 || cordic_load !== 1'b0 ||
            busy !== 1'b0 || out_valid !== 1'b0 || sin_out !== 16'h0 || cos_out !== 16'h0 ||
            in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_async: endangle=%h addr=%h load=%b busy=%b valid=%b sin=%h cos=%h in_ready=%b, required all 0 and in_ready=1",
                cordic_endangle, cordic_addr, cordic_load, busy, out_valid, sin_out, cos_out, in_ready); end
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        cordic_sin = 16'h5A5A; cordic_cos = 16'hA5A5;
        start = 1'b1; angle_in = 16'h1000;
        tick();
        start = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 18 || sin_out !== 16'h5A5A || cos_out !== 16'hA5A5 || cordic_endangle !== 16'h1000)
            begin failures++; $display("FAIL reset_fresh_op: result cycle=%0d sin=%h cos=%h endangle=%h, required 18/5a5a/a5a5/1000",
                n, sin_out, cos_out, cordic_endangle); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int n;
        int extra;
        cordic_sin = 16'h0F0F; cordic_cos = 16'hF0F0;
        start = 1'b1; angle_in = 16'h2500;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; angle_in = 16'h4000;
        tick();
        start = 1'b0; angle_in = 16'h0;
        checks++;
        if (cordic_endangle !== 16'h2500 || busy !== 1'b1)
            begin failures++; $display("FAIL ignore_start: endangle=%h busy=%b, required 2500/1", cordic_endangle, busy); end
        n = 6;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 18 || cordic_endangle !== 16'h2500 || sin_out !== 16'h0F0F)
            begin failures++; $display("FAIL ignore_start_result: result cycle=%0d endangle=%h sin=%h, required 18/2500/0f0f",
                n, cordic_endangle, sin_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0)
            begin failures++; $display("FAIL single_result: %0d cycles not idle after handoff, required 0", extra); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_abort_wait();
        test_reset_mid_op();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
